// File: rtl/twisted_ring_shifter_pkg.sv
// twisted_ring_shifter_pkg: shared mode and direction encodings
package twisted_ring_shifter_pkg;
  typedef enum logic [1:0] {
    MODE_HOLD    = 2'b00,
    MODE_SHIFT   = 2'b01,
    MODE_RING    = 2'b10,
    MODE_TWISTED = 2'b11
  } mode_e;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/twisted_ring_shifter_johnson_checker.sv
// twisted_ring_shifter_johnson_checker: flags a word with at most one adjacent-bit transition
module twisted_ring_shifter_johnson_checker #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] i_q,
  output logic             o_valid
);
  logic [WIDTH-2:0] w_edges;
  assign w_edges = i_q[WIDTH-2:0] ^ i_q[WIDTH-1:1];
  assign o_valid = (w_edges & (w_edges - 1'b1)) == '0;
endmodule

// File: rtl/twisted_ring_shifter.sv
// twisted_ring_shifter: configurable shift/ring/Johnson register with period counter
module twisted_ring_shifter
  import twisted_ring_shifter_pkg::*;
#(
  parameter int               WIDTH       = 6,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                          clk_input,
  input  logic                          clr_n_input,
  input  logic                          enable_input,
  input  logic                          load_input,
  input  logic [WIDTH-1:0]              load_value,
  input  logic                          data_input,
  input  logic                          dir_input,
  input  logic [1:0]                    mode_input,
  output logic [WIDTH-1:0]              shifted_number,
  output logic                          serial_output,
  output logic [$clog2(2*WIDTH)-1:0]    step_count,
  output logic                          period_done,
  output logic                          johnson_valid
);
  localparam int CW = $clog2(2*WIDTH);
  logic [WIDTH-1:0] r_q, w_next;
  logic [CW-1:0]    r_cnt, w_cnt_next, w_last;
  logic             r_done, w_out, w_fb, w_shift, w_periodic, w_restart, w_wrap;
  mode_e            r_mode_q;
  // feedback selection, next register value and period counter update
  always_comb begin
    w_out      = dir_input == DIR_RIGHT ? r_q[0] : r_q[WIDTH-1];
    w_fb       = mode_input == MODE_SHIFT ? data_input : mode_input == MODE_RING ? w_out : ~w_out;
    w_shift    = enable_input && mode_input != MODE_HOLD;
    w_next     = !w_shift ? r_q : dir_input == DIR_RIGHT ? {w_fb, r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], w_fb};
    w_periodic = mode_input == MODE_RING || mode_input == MODE_TWISTED;
    w_restart  = mode_input == MODE_SHIFT || (mode_input != MODE_HOLD && mode_input != r_mode_q);
    w_last     = mode_input == MODE_RING ? CW'(WIDTH - 1) : CW'(2 * WIDTH - 1);
    w_wrap     = w_shift && w_periodic && !w_restart && r_cnt == w_last;
    w_cnt_next = (w_restart || w_wrap) ? '0 : (w_shift && w_periodic) ? r_cnt + 1'b1 : r_cnt;
  end
  // state registers; load outranks every other control
  always_ff @(posedge clk_input or negedge clr_n_input) begin
    if (!clr_n_input) begin
      r_q      <= RESET_VALUE;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_mode_q <= MODE_HOLD;
    end else begin
      r_mode_q <= mode_e'(mode_input);
      if (load_input) begin
        r_q    <= load_value;
        r_cnt  <= '0;
        r_done <= 1'b0;
      end else begin
        r_q    <= w_next;
        r_cnt  <= w_cnt_next;
        r_done <= w_wrap;
      end
    end
  end
  twisted_ring_shifter_johnson_checker #(.WIDTH(WIDTH)) u_johnson (
    .i_q     (r_q),
    .o_valid (johnson_valid)
  );
  assign shifted_number = r_q;
  assign serial_output  = w_out;
  assign step_count     = r_cnt;
  assign period_done    = r_done;
endmodule

// File: tb/tb_twisted_ring_shifter.sv
// tb_twisted_ring_shifter: directed and random checks against a behavioural model
module tb_twisted_ring_shifter;
  localparam int W = 6;
  logic         clk = 0, clr_n = 0, en = 0, ld = 0, din = 0, dir = 0;
  logic [1:0]   mode = 0;
  logic [W-1:0] lv = 0;
  logic [W-1:0] q;
  logic [3:0]   cnt;
  logic         so, pd, jv;
  int total = 0, bad = 0;
  int mq, mcnt, mdone, mmode_q;
  twisted_ring_shifter #(.WIDTH(W)) dut (
    .clk_input(clk), .clr_n_input(clr_n), .enable_input(en), .load_input(ld),
    .load_value(lv), .data_input(din), .dir_input(dir), .mode_input(mode),
    .shifted_number(q), .serial_output(so), .step_count(cnt),
    .period_done(pd), .johnson_valid(jv)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  function automatic int johnson_ok(input int v);
    int t = 0;
    for (int i = 0; i < W - 1; i++)
      if (((v >> i) & 1) != ((v >> (i + 1)) & 1)) t++;
    return t <= 1 ? 1 : 0;
  endfunction
  function automatic void model_reset();
    mq = 0; mcnt = 0; mdone = 0; mmode_q = 0;
  endfunction
  function automatic void model_edge();
    int m = int'(mode);
    int period = (m == 2) ? W : 2 * W;
    bit changed = (m != 0) && (m != mmode_q);
    bit shifting = en && (m != 0);
    int outb, fb;
    if (ld) begin
      mq = int'(lv); mcnt = 0; mdone = 0;
    end else begin
      mdone = 0;
      if (shifting) begin
        outb = dir ? (mq % 2) : (mq / (1 << (W - 1)));
        fb = (m == 1) ? int'(din) : (m == 2) ? outb : 1 - outb;
        mq = dir ? (mq / 2 + fb * (1 << (W - 1))) : ((mq * 2) % (1 << W) + fb);
      end
      if (m == 1 || changed) mcnt = 0;
      else if (shifting) begin
        if (mcnt == period - 1) begin mcnt = 0; mdone = 1; end
        else mcnt++;
      end
    end
    mmode_q = m;
  endfunction
  task automatic check_all(input string tag);
    check({tag, ".q"}, q, mq);
    check({tag, ".cnt"}, cnt, mcnt);
    check({tag, ".pd"}, pd, mdone);
    check({tag, ".so"}, so, dir ? (mq & 1) : ((mq >> (W - 1)) & 1));
    check({tag, ".jv"}, jv, johnson_ok(mq));
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1 check_all(tag);
  endtask
  initial begin
    int bits[6] = '{1, 0, 1, 1, 0, 1};
    model_reset();
    #12 check_all("rst");
    @(negedge clk) clr_n = 1;
    mode = 2'b11; en = 0; dir = 0;
    step("tw_arm");
    en = 1;
    for (int i = 1; i <= 12; i++) begin
      step("tw");
      if (i == 6) check("tw_ones", q, 6'b111111);
      if (i == 11) check("tw_nopulse", pd, 0);
    end
    check("tw_back", q, 0);
    check("tw_pulse", pd, 1);
    mode = 2'b10; dir = 1; ld = 1; lv = 6'b100000; en = 0;
    step("ring_ld");
    ld = 0; en = 1;
    for (int i = 1; i <= 6; i++) begin
      step("ring");
      if (i == 2) begin
        check("ring_001000", q, 6'b001000);
        check("ring_jv0", jv, 0);
      end
    end
    check("ring_back", q, 6'b100000);
    check("ring_pulse", pd, 1);
    mode = 2'b01; dir = 0;
    for (int i = 0; i < 6; i++) begin
      din = bits[i];
      step("shift");
      check("shift_cnt0", cnt, 0);
    end
    check("shift_val", q, 6'b101101);
    mode = 2'b11; en = 1; ld = 1; lv = 6'b101010;
    step("load");
    check("load_val", q, 6'b101010);
    check("load_cnt", cnt, 0);
    ld = 0; en = 0;
    for (int i = 0; i < 5; i++) step("hold");
    check("hold_val", q, 6'b101010);
    en = 1;
    for (int i = 0; i < 7; i++) step("pre_sw");
    check("pre_sw_cnt", cnt, 7);
    mode = 2'b10;
    step("sw");
    check("sw_cnt", cnt, 0);
    for (int i = 1; i <= 6; i++) step("post_sw");
    check("post_sw_pulse", pd, 1);
    step("run");
    step("run");
    #3 clr_n = 0;
    #1;
    model_reset();
    check("async_q", q, 0);
    check("async_cnt", cnt, 0);
    check("async_pd", pd, 0);
    @(negedge clk) clr_n = 1;
    for (int i = 0; i < 500; i++) begin
      ld = $urandom_range(0, 15) == 0;
      lv = W'($urandom);
      en = $urandom_range(0, 3) != 0;
      din = 1'($urandom);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      if ($urandom_range(0, 11) == 0) mode = 2'($urandom);
      step("rnd");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
